// File: rtl/tile_frame_writer.sv
// Back-buffer renderer: on every buf_sel toggle, writes the maze and score bytes to the frame RAM in linear order.
// Optional macro TILE_FRAME_WRITER_ZERO_BLANK_EN blanks leading zero score digits.
module tile_frame_writer #(
    parameter int MAZE_W_TILES = 30,
    parameter int MAZE_H_TILES = 33,
    parameter int SCORE_ADDR0  = 63360,
    parameter int SCORE_DIGITS = 7,
    parameter int DIGIT_BASE   = 240,
    parameter int BLANK_TILE   = 250,
    parameter int PARK_ADDR    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        buf_sel,
    input  logic [27:0] score_bcd,
    output logic [9:0]  tile_addr,
    input  logic [7:0]  tile_code,
    output logic [13:0] pat_addr,
    input  logic [7:0]  pat_data,
    output logic [15:0] addrWrite,
    output logic [7:0]  dataWrite,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int MAZE_W_PX  = MAZE_W_TILES * 8;
    localparam int MAZE_H_PX  = MAZE_H_TILES * 8;
    localparam int SCORE_W_PX = SCORE_DIGITS * 8;

    typedef enum logic [1:0] {IDLE, MAZE, SCORE, FLUSH} state_t;

    state_t      state_q, state_d;
    logic        buf_sel_q, buf_sel_d;
    logic [27:0] score_q, score_d;
    logic [15:0] k_q, k_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [5:0]  xs_q, xs_d;
    logic [2:0]  ys_q, ys_d;
    logic        flush_q, flush_d;
    logic [9:0]  tile_addr_q, tile_addr_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_score_q, s1_score_d;
    logic [2:0]  s1_px_q, s1_px_d;
    logic [2:0]  s1_py_q, s1_py_d;
    logic [15:0] s1_dest_q, s1_dest_d;
    logic [7:0]  s1_code_q, s1_code_d;
    logic        s2_valid_q, s2_valid_d;
    logic [15:0] s2_dest_q, s2_dest_d;

    logic        swap;
    logic [2:0]  digit_idx;
    logic [3:0]  digit_v;
    logic [3:0]  nib;
    logic        all_zero;
    logic        lead_zero;
    logic [7:0]  digit_code;
    logic [15:0] score_dest;
    logic [7:0]  pat_code;

    assign swap       = (buf_sel != buf_sel_q);
    assign score_dest = 16'(SCORE_ADDR0 + int'(ys_q) * SCORE_W_PX + int'(xs_q));

    // Digit under the score cursor, plus whether it and every more-significant digit are zero.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        digit_idx = xs_q[5:3];
        digit_v   = 4'd0;
        nib       = 4'd0;
        all_zero  = 1'b1;
        lead_zero = 1'b0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            nib      = score_q[4*(SCORE_DIGITS-1-i) +: 4];
            all_zero = all_zero && (nib == 4'd0);
            if (3'(i) == digit_idx) begin
                digit_v   = nib;
                lead_zero = all_zero && (i != SCORE_DIGITS - 1);
            end
        end
`ifdef TILE_FRAME_WRITER_ZERO_BLANK_EN
        if (lead_zero || digit_v > 4'd9) digit_code = 8'(BLANK_TILE);
        else                             digit_code = 8'(DIGIT_BASE) + {4'd0, digit_v};
`else
        if (digit_v > 4'd9) digit_code = 8'(BLANK_TILE);
        else                digit_code = 8'(DIGIT_BASE) + {4'd0, digit_v};
`endif
    end

    always_comb begin
        state_d      = state_q;
        buf_sel_d    = buf_sel;
        score_d      = score_q;
        k_d          = k_q;
        x_d          = x_q;
        y_d          = y_q;
        xs_d         = xs_q;
        ys_d         = ys_q;
        flush_d      = flush_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;

        s1_valid_d = (state_q == MAZE) || (state_q == SCORE);
        s1_score_d = (state_q == SCORE);
        s1_px_d    = (state_q == SCORE) ? xs_q[2:0] : x_q[2:0];
        s1_py_d    = (state_q == SCORE) ? ys_q : y_q[2:0];
        s1_dest_d  = (state_q == SCORE) ? score_dest : k_q;
        s1_code_d  = digit_code;
        s2_valid_d = s1_valid_q;
        s2_dest_d  = s1_dest_q;

        case (state_q)
            MAZE: begin
                k_d = k_q + 16'd1;
                if (x_q == 8'(MAZE_W_PX - 1)) begin
                    x_d = 8'd0;
                    if (y_q == 9'(MAZE_H_PX - 1)) begin
                        state_d = SCORE;
                        xs_d    = 6'd0;
                        ys_d    = 3'd0;
                    end else begin
                        y_d = y_q + 9'd1;
                    end
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            SCORE: begin
                if (xs_q == 6'(SCORE_W_PX - 1)) begin
                    xs_d = 6'd0;
                    if (ys_q == 3'd7) begin
                        state_d = FLUSH;
                        flush_d = 1'b0;
                    end else begin
                        ys_d = ys_q + 3'd1;
                    end
                end else begin
                    xs_d = xs_q + 6'd1;
                end
            end
            FLUSH: begin
                if (flush_q) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    flush_d = 1'b1;
                end
            end
            default: ;
        endcase

        // A swap on the last flush cycle completes the old frame normally; any earlier one aborts it.
        if (swap) begin
            overrun_d  = (state_q != IDLE) && !(state_q == FLUSH && flush_q);
            state_d    = MAZE;
            score_d    = score_bcd;
            k_d        = 16'd0;
            x_d        = 8'd0;
            y_d        = 9'd0;
            xs_d       = 6'd0;
            ys_d       = 3'd0;
            flush_d    = 1'b0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end

        busy_d      = (state_d != IDLE);
        tile_addr_d = (state_d == MAZE)
                    ? ({4'd0, y_d[8:3]} * 10'(MAZE_W_TILES) + {5'd0, x_d[7:3]})
                    : tile_addr_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_sel_q    <= 1'b0;
            score_q      <= '0;
            k_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            xs_q         <= '0;
            ys_q         <= '0;
            flush_q      <= 1'b0;
            tile_addr_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_score_q   <= 1'b0;
            s1_px_q      <= '0;
            s1_py_q      <= '0;
            s1_dest_q    <= '0;
            s1_code_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_dest_q    <= '0;
        end else begin
            state_q      <= state_d;
            buf_sel_q    <= buf_sel_d;
            score_q      <= score_d;
            k_q          <= k_d;
            x_q          <= x_d;
            y_q          <= y_d;
            xs_q         <= xs_d;
            ys_q         <= ys_d;
            flush_q      <= flush_d;
            tile_addr_q  <= tile_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            s1_valid_q   <= s1_valid_d;
            s1_score_q   <= s1_score_d;
            s1_px_q      <= s1_px_d;
            s1_py_q      <= s1_py_d;
            s1_dest_q    <= s1_dest_d;
            s1_code_q    <= s1_code_d;
            s2_valid_q   <= s2_valid_d;
            s2_dest_q    <= s2_dest_d;
        end
    end

    assign pat_code   = s1_score_q ? s1_code_q : tile_code;
    assign pat_addr   = {pat_code, s1_py_q, s1_px_q};
    assign tile_addr  = tile_addr_q;
    assign addrWrite  = s2_valid_q ? s2_dest_q : 16'(PARK_ADDR);
    assign dataWrite  = s2_valid_q ? pat_data : 8'd0;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
